// File: rtl/aes128_key_expand.sv
// AES-128 key schedule: expands key_in into 11 round keys, one round key per
// clock through a single shared SubWord, with a combinational read port.
module aes128_key_expand #(
  parameter int RESTART = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         busy,
  output logic         ready,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   rnd;
  logic [127:0] rk [0:10];
  logic         accept, last_round;
  logic [127:0] prev_rk, next_rk;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w0, w1, w2, w3;

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_round = 1'b0;
    case (state)
      IDLE, READY: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (start && (RESTART != 0)) begin
          accept = 1'b1;
        end else if (rnd == 4'd10) begin
          last_round = 1'b1;
          state_nxt  = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round datapath: rk[rnd] is derived from rk[rnd-1] through the one SubWord.
  always_comb begin
    prev_rk = '0;
    for (int i = 1; i <= 10; i++)
      if (rnd == 4'(i)) prev_rk = rk[i-1];
  end

  assign rot_w   = {prev_rk[23:0], prev_rk[31:24]};
  assign sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
  assign t_w     = sub_w ^ {rcon(rnd), 24'h000000};
  assign w0      = prev_rk[127:96] ^ t_w;
  assign w1      = prev_rk[95:64]  ^ w0;
  assign w2      = prev_rk[63:32]  ^ w1;
  assign w3      = prev_rk[31:0]   ^ w2;
  assign next_rk = {w0, w1, w2, w3};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rnd   <= '0;
      done  <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= last_round;
      if (accept) begin
        rk[0] <= key_in;
        rnd   <= 4'd1;
      end else if (state == EXPAND) begin
        for (int i = 1; i <= 10; i++)
          if (rnd == 4'(i)) rk[i] <= next_rk;
        rnd <= rnd + 4'd1;
      end
    end
  end

  assign busy  = (state == EXPAND);
  assign ready = (state == READY);

  // rnd counts entries written since the last accept (11 once complete).
  always_comb begin
    rk_out   = '0;
    rk_valid = 1'b0;
    if (rk_idx <= 4'd10) begin
      rk_out   = rk[rk_idx];
      rk_valid = (rk_idx < rnd);
    end
  end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Scoreboard bench for aes128_key_expand: two instances (RESTART=0 and 1) share
// stimulus; a GF(2^8)-based key-schedule model feeds per-instance queues.
`timescale 1ns/1ps
module tb_aes128_key_expand;

  typedef logic [0:10][127:0] sched_t;
  typedef struct {
    sched_t rk;
    int     t0;
  } txn_t;

  localparam bit RESTART_OF [2] = '{1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out [2];
  logic         rk_valid [2];
  logic         busy [2];
  logic         ready [2];
  logic         done [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] sb [256];
  txn_t       q [2][$];
  int         t0s [2];
  bit         active [2];
  sched_t     last [2];
  bit         have_last [2];

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_key_expand #(.RESTART(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_idx(rk_idx),
    .rk_out(rk_out[0]), .rk_valid(rk_valid[0]), .busy(busy[0]), .ready(ready[0]), .done(done[0])
  );

  aes128_key_expand #(.RESTART(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_idx(rk_idx),
    .rk_out(rk_out[1]), .rk_valid(rk_valid[1]), .busy(busy[1]), .ready(ready[1]), .done(done[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box = affine transform of the multiplicative inverse (x^254).
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = x;
      for (int i = 0; i < 253; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic sched_t expand_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  task automatic chk(input string what, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", what, d, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int     n, i;
    bit     zero_mode;
    sched_t s;
    have_last = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n = 0;
        zero_mode = 1'b0;
        s = '0;
        if (rst !== 1'b1) begin
          chk("busy_reset", d, busy[d], 0);
          chk("ready_reset", d, ready[d], 0);
          chk("done_reset", d, done[d], 0);
          have_last[d] = 1'b0;
          zero_mode = 1'b1;
        end else if (q[d].size() > 0) begin
          i = cyc - q[d][0].t0 - 1;
          chk("busy", d, busy[d], (i < 10));
          chk("ready", d, ready[d], (i >= 10));
          chk("done", d, done[d], (i == 10));
          n = (i + 1 > 11) ? 11 : i + 1;
          s = q[d][0].rk;
          if (i >= 10) begin
            last[d] = s;
            have_last[d] = 1'b1;
            void'(q[d].pop_front());
          end
        end else begin
          chk("busy_quiet", d, busy[d], 0);
          chk("done_spurious", d, done[d], 0);
          chk("ready_quiet", d, ready[d], have_last[d]);
          if (have_last[d]) begin
            n = 11;
            s = last[d];
          end else begin
            zero_mode = 1'b1;
          end
        end
        for (int idx = 0; idx < 16; idx++) begin
          rk_idx = 4'(idx);
          #1;
          chk($sformatf("rk_valid[%0d]", idx), d, rk_valid[d], (idx < n));
          if (idx < n) chk($sformatf("rk_out[%0d]", idx), d, rk_out[d], s[idx]);
          else if (idx > 10 || zero_mode) chk($sformatf("rk_out_zero[%0d]", idx), d, rk_out[d], '0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit expanding(input int d, input int c);
    return active[d] && ((c - t0s[d] - 1) <= 9);
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [127:0] key);
    int     c;
    bit     acc [2];
    bit     rs [2];
    sched_t s;
    txn_t   t;
    c = cyc;
    s = expand_ref(key);
    start = 1'b1;
    key_in = key;
    for (int d = 0; d < 2; d++) begin
      rs[d]  = expanding(d, c);
      acc[d] = !rs[d] || RESTART_OF[d];
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        t.rk = s;
        t.t0 = c;
        if (rs[d]) q[d][0] = t;
        else q[d].push_back(t);
        t0s[d] = c;
        active[d] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q[0].delete();
    q[1].delete();
    active = '{1'b0, 1'b0};
    repeat (cycles) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    key_in = '0;
    rk_idx = '0;
    active = '{1'b0, 1'b0};
    for (int x = 0; x < 256; x++) sb[x] = sbox_ref(8'(x));

    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // known-answer keys, the last two back-to-back after done
    issue(KEY_FIPS);
    repeat (11) @(negedge clk);
    issue('0);
    repeat (10) @(negedge clk);
    issue(KEY_SEQ);
    repeat (10) @(negedge clk);
    issue({$urandom, $urandom, $urandom, $urandom});
    repeat (12) @(negedge clk);

    // start while busy: ignored by RESTART=0, restarts RESTART=1
    issue(KEY_FIPS);
    repeat (3) @(negedge clk);
    issue('0);
    repeat (13) @(negedge clk);

    // reset in the middle of an expansion, then a fresh run
    issue(KEY_FIPS);
    repeat (4) @(negedge clk);
    pulse_reset(2);
    issue(KEY_FIPS);
    repeat (11) @(negedge clk);

    // random keys with random gaps, including back-to-back
    for (int k = 0; k < 4; k++) begin
      issue({$urandom, $urandom, $urandom, $urandom});
      repeat (10 + $urandom_range(0, 2)) @(negedge clk);
    end
    issue({$urandom, $urandom, $urandom, $urandom});
    repeat ($urandom_range(1, 8)) @(negedge clk);
    issue({$urandom, $urandom, $urandom, $urandom});
    repeat (13) @(negedge clk);

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("pending_txn", d, q[d].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
